// File: rtl/solitaire_pkg.sv
// ============================================================================
// Module      : solitaire_pkg
// Description : Shared peg-solitaire definitions: directions, board mask,
//               idle coordinate and input-controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package solitaire_pkg;

  localparam int BOARD_WIDTH = 7;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [2:0] IDLE_COORD = 3'd7;

  // Bit (y*7 + x) is set where a hole exists; row 0 is the least significant.
  localparam logic [48:0] SPACE_MASK = {7'h1C, 7'h1C, 7'h7F, 7'h7F, 7'h7F, 7'h1C, 7'h1C};

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_SELECT = 4;

  typedef enum logic [1:0] {
    NAVIGATE = 2'd0,
    ARMED    = 2'd1,
    COMMIT   = 2'd2
  } ctrl_state_t;

  function automatic logic space_at(input logic [2:0] x, input logic [2:0] y);
    logic [5:0] idx;
    idx = 6'(y) * 6'(BOARD_WIDTH) + 6'(x);
    return SPACE_MASK[idx];
  endfunction

  function automatic logic signed [4:0] dir_dx(input logic [1:0] d);
    case (d)
      DIR_LEFT:  return -5'sd1;
      DIR_RIGHT: return 5'sd1;
      default:   return 5'sd0;
    endcase
  endfunction

  function automatic logic signed [4:0] dir_dy(input logic [1:0] d);
    case (d)
      DIR_UP:   return -5'sd1;
      DIR_DOWN: return 5'sd1;
      default:  return 5'sd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/solitaire_debounce.sv
// ============================================================================
// Module      : solitaire_debounce
// Description : Two-flop synchronizer, stability counter and rising-edge
//               press pulse for one raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module solitaire_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_count;

  // The level flips only once the synchronized value has disagreed with it
  // on DEBOUNCE_CYCLES + 1 consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_count <= '0;
      press   <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      press   <= 1'b0;
      if (r_sync2 == r_level) begin
        r_count <= '0;
      end else if (r_count == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_level <= r_sync2;
        r_count <= '0;
        press   <= r_sync2;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/solitaire_input_ctrl.sv
// ============================================================================
// Module      : solitaire_input_ctrl
// Description : Debounced cursor navigation and single-cycle move requests
//               for the peg-solitaire board core. SOLITAIRE_CURSOR_FOLLOW_EN
//               makes the cursor jump to the landing space after a commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module solitaire_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOARD_WIDTH     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  output logic [2:0] piece_x,
  output logic [2:0] piece_y,
  output logic [1:0] direction,
  output logic       move_strobe,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       armed
);

  import solitaire_pkg::*;

  logic [4:0]        w_raw;
  logic [4:0]        w_press;
  logic              w_dir_hit;
  logic [1:0]        w_dir;
  logic signed [4:0] w_cur_x, w_cur_y;
  logic signed [4:0] w_nav_x, w_nav_y, w_land_x, w_land_y;
  logic              w_nav_ok, w_land_ok, w_follow;
  ctrl_state_t       r_state;

  assign w_raw = {btn_select, btn_down, btn_up, btn_right, btn_left};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    solitaire_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (w_raw[i]),
      .press   (w_press[i])
    );
  end

  function automatic logic on_board(input logic signed [4:0] x, input logic signed [4:0] y);
    return !x[4] && !y[4] && (x < 5'(BOARD_WIDTH)) && (y < 5'(BOARD_WIDTH))
           && space_at(x[2:0], y[2:0]);
  endfunction

  always_comb begin
    w_dir_hit = |w_press[BTN_DOWN:BTN_LEFT];
    w_dir     = DIR_LEFT;
    if (w_press[BTN_LEFT])       w_dir = DIR_LEFT;
    else if (w_press[BTN_RIGHT]) w_dir = DIR_RIGHT;
    else if (w_press[BTN_UP])    w_dir = DIR_UP;
    else if (w_press[BTN_DOWN])  w_dir = DIR_DOWN;

    w_cur_x   = $signed({2'b00, cursor_x});
    w_cur_y   = $signed({2'b00, cursor_y});
    w_nav_x   = w_cur_x + dir_dx(w_dir);
    w_nav_y   = w_cur_y + dir_dy(w_dir);
    w_nav_ok  = on_board(w_nav_x, w_nav_y);
    // During COMMIT the direction output holds the latched move direction.
    w_land_x  = w_cur_x + (dir_dx(direction) <<< 1);
    w_land_y  = w_cur_y + (dir_dy(direction) <<< 1);
    w_land_ok = on_board(w_land_x, w_land_y);
`ifdef SOLITAIRE_CURSOR_FOLLOW_EN
    w_follow  = 1'b1;
`else
    w_follow  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= NAVIGATE;
      cursor_x    <= 3'd3;
      cursor_y    <= 3'd3;
      armed       <= 1'b0;
      piece_x     <= IDLE_COORD;
      piece_y     <= IDLE_COORD;
      direction   <= DIR_LEFT;
      move_strobe <= 1'b0;
    end else begin
      case (r_state)
        NAVIGATE: begin
          if (w_press[BTN_SELECT]) begin
            r_state <= ARMED;
            armed   <= 1'b1;
          end else if (w_dir_hit && w_nav_ok) begin
            cursor_x <= w_nav_x[2:0];
            cursor_y <= w_nav_y[2:0];
          end
        end
        ARMED: begin
          if (w_press[BTN_SELECT]) begin
            r_state <= NAVIGATE;
            armed   <= 1'b0;
          end else if (w_dir_hit) begin
            r_state     <= COMMIT;
            armed       <= 1'b0;
            piece_x     <= cursor_x;
            piece_y     <= cursor_y;
            direction   <= w_dir;
            move_strobe <= 1'b1;
          end
        end
        COMMIT: begin
          r_state     <= NAVIGATE;
          piece_x     <= IDLE_COORD;
          piece_y     <= IDLE_COORD;
          direction   <= DIR_LEFT;
          move_strobe <= 1'b0;
          if (w_follow && w_land_ok) begin
            cursor_x <= w_land_x[2:0];
            cursor_y <= w_land_y[2:0];
          end
        end
        default: r_state <= NAVIGATE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/solitaire_input_ctrl.md
Name: solitaire_input_ctrl

Overview:
- Upstream stage of the peg-solitaire board core. Converts five raw push-buttons into a navigable cursor and single-cycle move requests on the core's piece_x / piece_y / direction inputs.
- The board core applies any legal move it is presented on every clock. This block therefore parks its request outputs on an off-board coordinate (7,7) except during a one-cycle commit.
- Cursor position and armed state are also exported for a display stage.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a button level change is accepted (min 1).
- BOARD_WIDTH, 7, board edge length; coordinates 0..6, 7 reserved as "no request".

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- btn_left  input  1  raw button, async to clk, active-high
- btn_right  input  1  raw button
- btn_up  input  1  raw button
- btn_down  input  1  raw button
- btn_select  input  1  raw button; arm/cancel
- piece_x  output  3  move request x to board core; 7 when idle
- piece_y  output  3  move request y to board core; 7 when idle
- direction  output  2  move direction: LEFT=00, RIGHT=01, UP=10, DOWN=11
- move_strobe  output  1  high during the single commit cycle
- cursor_x  output  3  current cursor x
- cursor_y  output  3  current cursor y
- armed  output  1  high in ARMED state

Behaviour:
- Reset values: piece_x=7, piece_y=7, direction=00, move_strobe=0, cursor=(3,3), armed=0, state=NAVIGATE, all debounced levels 0, all counters 0.
- Per button:
  - 2-flop synchronizer.
  - Counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse.
  - Latency: a raw level held from sample edge N gives a press pulse in cycle N+2+DEBOUNCE_CYCLES. Shorter glitches produce no pulse. Release produces no pulse.
- Simultaneous press pulses in one cycle: select > left > right > up > down. Only the winner is acted on; the others are discarded, not queued.
- NAVIGATE:
  - Direction press moves the cursor one step if the destination lies within 0..6 and is a real board space (cross-shaped mask). Otherwise the cursor is unchanged.
  - Select press goes to ARMED.
- ARMED:
  - armed=1 and the cursor is frozen.
  - Select press cancels and returns to NAVIGATE.
  - Direction press goes to COMMIT with the latched direction.
- COMMIT (exactly one cycle):
  - Registered outputs piece_x=cursor_x, piece_y=cursor_y, direction=latched, move_strobe=1.
  - Next state is always NAVIGATE, and outputs return to 7/7/00/0.
  - Press pulses arriving during COMMIT are discarded.
- Legality is decided only by the board core; an illegal commit is a silent no-op there.
- Output timing: press pulse in cycle C → outputs change at the edge ending C (visible in C+1).
- Reset asserted mid-debounce or mid-COMMIT: immediate return to reset values. No partial request may remain on piece_x/piece_y.

Optional Feature:
- Macro: SOLITAIRE_CURSOR_FOLLOW_EN.
- Defined: on COMMIT, the cursor jumps to the landing space (two steps in the committed direction) if that space is on-board. Otherwise the cursor is unchanged.
- Undefined: the cursor stays at the committed origin.

Decomposition:
- Shared package (also used by the board core):
  - Direction encoding constants LEFT/RIGHT/UP/DOWN.
  - BOARD_WIDTH.
  - 49-bit space-exists mask constant.
  - Idle coordinate constant 3'd7.
  - Controller state enum {NAVIGATE, ARMED, COMMIT}.
- Sub-module solitaire_debounce (synchronizer + counter + edge detect), instantiated five times.

Test Plan:
- DEBOUNCE_CYCLES=4; 3-cycle high glitch on btn_up → no pulse, cursor stays (3,3). 10-cycle hold → pulse at cycle 6 after first sample, cursor (3,2).
- From reset, btn_up ×4 → cursor (3,2),(3,1),(3,0),(3,0); then btn_left ×2 → (2,0),(2,0) (blocked, (1,0) dead).
- Cursor (3,1), select, btn_down → exactly one cycle with piece=(3,1), direction=11, move_strobe=1. With the core attached: piece_count 32→31, board (3,1)=0, (3,2)=0, (3,3)=1. Outputs return to (7,7)/00.
- Select then select → armed 1→0, no strobe ever, piece outputs stay 7/7.
- btn_select and btn_left pulses in the same cycle in NAVIGATE → ARMED entered, cursor unchanged.
- Assert rst_n low during the COMMIT cycle → piece=(7,7), move_strobe=0, cursor (3,3), armed=0 immediately. With SOLITAIRE_CURSOR_FOLLOW_EN, a commit DOWN from (3,1) gives cursor (3,3).
